rs_lat_seq: RTL

- Sequencing controller for a bank of N cross-coupled NAND RS latches with active-low rn/sn inputs.
- Arbitrates set/clear requests from two requesters, A and B, using round-robin.
- Drives timed active-low pulses onto one latch at a time and never drives the forbidden rn=sn=0 combination.
- Reads back the latch q output and reports a per-operation error on the requester's acknowledge.

---
 rtl/rs_lat_seq.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/rs_lat_seq.sv
// rs_lat_seq: round-robin sequencer that drives timed active-low set/clear
// pulses onto a bank of NAND RS latches and reads each latch back before
// acknowledging the requester.
module rs_lat_seq #(
   parameter int unsigned N         = 8,
   parameter int unsigned IDXW      = 3,
   parameter int unsigned PULSE_CYC = 2,
   parameter int unsigned RECOV_CYC = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            a_req,
   input  logic            a_op,
   input  logic [IDXW-1:0] a_idx,
   output logic            a_ack,
   output logic            a_err,
   input  logic            b_req,
   input  logic            b_op,
   input  logic [IDXW-1:0] b_idx,
   output logic            b_ack,
   output logic            b_err,
   output logic [N-1:0]    lat_rn,
   output logic [N-1:0]    lat_sn,
   input  logic [N-1:0]    lat_q,
   output logic            busy
);

   // Counter is sized for the longer of the two timed phases.
   localparam int unsigned CNT_MAX = (PULSE_CYC > RECOV_CYC) ? PULSE_CYC : RECOV_CYC;
   localparam int unsigned CNTW    = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_PULSE = 2'd1,
      S_RECOV = 2'd2,
      S_CHECK = 2'd3
   } state_e;

   // FSM and captured-operation state
   state_e            state_q, state_d;
   logic [CNTW-1:0]   cnt_q, cnt_d;
   logic              ptr_b_q, ptr_b_d;   // 0 = A has priority, 1 = B
   logic              gnt_b_q, gnt_b_d;   // side currently being served
   logic              op_q, op_d;
   logic [IDXW-1:0]   idx_q, idx_d;
   logic              ferr_q, ferr_d;     // forced error (bad index)

   // q synchroniser
   logic [N-1:0]      sync1_q, sync2_q;

   // Registered outputs
   logic [N-1:0]      lat_rn_q, lat_rn_d;
   logic [N-1:0]      lat_sn_q, lat_sn_d;
   logic              a_ack_q, a_ack_d;
   logic              a_err_q, a_err_d;
   logic              b_ack_q, b_ack_d;
   logic              b_err_q, b_err_d;
   logic              busy_q, busy_d;

   // Arbitration helpers
   logic              grant;
   logic              sel_b;
   logic              sel_op;
   logic [IDXW-1:0]   sel_idx;
   logic              sel_idx_ok;
   logic              ack_pending;

   // Readback helpers
   logic              rb_bit;
   logic              chk_err;

   // Round-robin selection; only consumed when the FSM is idle.
   always_comb begin
      grant = 1'b0;
      sel_b = 1'b0;
      if (a_req && b_req) begin
         grant = 1'b1;
         sel_b = ptr_b_q;
      end else if (a_req) begin
         grant = 1'b1;
         sel_b = 1'b0;
      end else if (b_req) begin
         grant = 1'b1;
         sel_b = 1'b1;
      end
      sel_op     = sel_b ? b_op : a_op;
      sel_idx    = sel_b ? b_idx : a_idx;
      sel_idx_ok = (32'(sel_idx) < N);
   end

   // Requesters still see their ack this cycle, so their req is stale.
   assign ack_pending = a_ack_q | b_ack_q;

   // Next-state logic: grant, timed pulse, recovery, readback.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ptr_b_d = ptr_b_q;
      gnt_b_d = gnt_b_q;
      op_d    = op_q;
      idx_d   = idx_q;
      ferr_d  = ferr_q;
      unique case (state_q)
         S_IDLE: begin
            if (grant && !ack_pending) begin
               gnt_b_d = sel_b;
               ptr_b_d = ~sel_b;
               op_d    = sel_op;
               idx_d   = sel_idx;
               if (sel_idx_ok) begin
                  state_d = S_PULSE;
                  cnt_d   = CNTW'(PULSE_CYC - 1);
                  ferr_d  = 1'b0;
               end else begin
                  state_d = S_CHECK;
                  cnt_d   = '0;
                  ferr_d  = 1'b1;
               end
            end
         end
         S_PULSE: begin
            if (cnt_q == '0) begin
               state_d = S_RECOV;
               cnt_d   = CNTW'(RECOV_CYC - 2);
            end else begin
               cnt_d = cnt_q - CNTW'(1);
            end
         end
         // CHECK itself is the final recovery cycle, so RECOV lasts one less.
         S_RECOV: begin
            if (cnt_q == '0) begin
               state_d = S_CHECK;
            end else begin
               cnt_d = cnt_q - CNTW'(1);
            end
         end
         S_CHECK: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         ptr_b_q <= 1'b0;
         gnt_b_q <= 1'b0;
         op_q    <= 1'b0;
         idx_q   <= '0;
         ferr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ptr_b_q <= ptr_b_d;
         gnt_b_q <= gnt_b_d;
         op_q    <= op_d;
         idx_q   <= idx_d;
         ferr_q  <= ferr_d;
      end
   end

   // Output decode: pulses follow the next state so they align with PULSE.
   always_comb begin
      lat_rn_d = '1;
      lat_sn_d = '1;
      if (state_d == S_PULSE) begin
         for (int unsigned i = 0; i < N; i++) begin
            if (idx_d == IDXW'(i)) begin
               if (op_d) begin
                  lat_sn_d[i] = 1'b0;
               end else begin
                  lat_rn_d[i] = 1'b0;
               end
            end
         end
      end

      rb_bit = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         if (idx_q == IDXW'(i)) begin
            rb_bit = sync2_q[i];
         end
      end
      chk_err = ferr_q | (rb_bit != op_q);

      a_ack_d = (state_q == S_CHECK) && !gnt_b_q;
      b_ack_d = (state_q == S_CHECK) && gnt_b_q;
      a_err_d = a_ack_d && chk_err;
      b_err_d = b_ack_d && chk_err;
      busy_d  = (state_d != S_IDLE);
   end

   // Output registers and the two-flop q synchroniser
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q  <= '0;
         sync2_q  <= '0;
         lat_rn_q <= '1;
         lat_sn_q <= '1;
         a_ack_q  <= 1'b0;
         a_err_q  <= 1'b0;
         b_ack_q  <= 1'b0;
         b_err_q  <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         sync1_q  <= lat_q;
         sync2_q  <= sync1_q;
         lat_rn_q <= lat_rn_d;
         lat_sn_q <= lat_sn_d;
         a_ack_q  <= a_ack_d;
         a_err_q  <= a_err_d;
         b_ack_q  <= b_ack_d;
         b_err_q  <= b_err_d;
         busy_q   <= busy_d;
      end
   end

   assign lat_rn = lat_rn_q;
   assign lat_sn = lat_sn_q;
   assign a_ack  = a_ack_q;
   assign a_err  = a_err_q;
   assign b_ack  = b_ack_q;
   assign b_err  = b_err_q;
   assign busy   = busy_q;

endmodule
